// File: rtl/crp16_run_controller.sv
// Sequences the crp16 datapath through program load, run and halt, and owns the RAM port-B mux.
// Latency: state, cpu_reset and status update one clock after the request; port-B mux and load_ready are combinational.
// Backpressure: load_ready is high only in LOAD; a word is taken on load_valid & load_ready, and no wait states are inserted.
module crp16_run_controller #(
    parameter logic [15:0] LOAD_BASE  = 16'h0000,
    parameter logic [15:0] LOAD_LIMIT = 16'hFFFF,
    parameter int          CYC_W      = 32,
    parameter int          WATCHDOG   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [15:0]      load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             run_req,
    input  logic             abort_req,
    output logic             cpu_reset,
    input  logic [15:0]      cpu_instr,
    input  logic [15:0]      cpu_addr_b,
    input  logic [15:0]      cpu_data_b,
    input  logic             cpu_wren_b,
    output logic [15:0]      mem_addr_b,
    output logic [15:0]      mem_data_b,
    output logic             mem_wren_b,
    output logic [1:0]       state,
    output logic [15:0]      load_addr,
    output logic             load_err,
    output logic             timeout,
    output logic [CYC_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [15:0]      STOP_INSTR = 16'h8000;
    localparam logic [CYC_W-1:0] WD_LAST    = (WATCHDOG == 0) ? '0 : CYC_W'(WATCHDOG - 1);

    state_t cur;
    logic   load_pend;   // load_start seen in HALT, replayed once IDLE is reached
    logic   accept;
    logic   stop_hit;
    logic   wd_hit;

    assign state      = cur;
    assign load_ready = (cur == S_LOAD);
    assign accept     = load_ready & load_valid;
    assign stop_hit   = (cpu_instr == STOP_INSTR);
    assign wd_hit     = (WATCHDOG != 0) && (run_cycles == WD_LAST);

    // Port-B mux: loader owns the RAM in LOAD, datapath owns it in RUN, writes blocked otherwise.
    always_comb begin
        mem_addr_b = cpu_addr_b;
        mem_data_b = cpu_data_b;
        mem_wren_b = 1'b0;
        if (cur == S_LOAD) begin
            mem_addr_b = load_addr;
            mem_data_b = load_data;
            mem_wren_b = accept;
        end else if (cur == S_RUN) begin
            mem_wren_b = cpu_wren_b;
        end
    end

    // Phase sequencer with registered datapath reset, load pointer and run statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur        <= S_IDLE;
            cpu_reset  <= 1'b0;
            load_addr  <= LOAD_BASE;
            load_err   <= 1'b0;
            timeout    <= 1'b0;
            run_cycles <= '0;
            load_pend  <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    cpu_reset <= 1'b0;
                    load_pend <= 1'b0;
                    if (load_start || load_pend) begin
                        cur       <= S_LOAD;
                        load_addr <= LOAD_BASE;
                        load_err  <= 1'b0;
                    end else if (run_req) begin
                        cur        <= S_RUN;
                        cpu_reset  <= 1'b1;
                        run_cycles <= '0;
                        timeout    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    cpu_reset <= 1'b0;
                    if (accept) begin
                        if (load_last) begin
                            load_addr <= load_addr + 16'd1;
                            cur       <= S_IDLE;
                        end else if (load_addr == LOAD_LIMIT) begin
                            // Image does not fit: keep the pointer pinned at the limit rather than wrapping.
                            load_err <= 1'b1;
                            cur      <= S_IDLE;
                        end else begin
                            load_addr <= load_addr + 16'd1;
                        end
                    end
                    if (abort_req) begin
                        cur <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (run_cycles != '1) begin
                        run_cycles <= run_cycles + 1'b1;
                    end
                    if (abort_req) begin
                        cur       <= S_IDLE;
                        cpu_reset <= 1'b0;
                    end else if (stop_hit) begin
                        cur <= S_HALT;
                    end else if (wd_hit) begin
                        timeout <= 1'b1;
                        cur     <= S_HALT;
                    end
                end
                S_HALT: begin
                    // Datapath stays out of reset so its register view remains readable.
                    if (abort_req || load_start) begin
                        cur       <= S_IDLE;
                        cpu_reset <= 1'b0;
                        load_pend <= load_start;
                    end
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crp16_run_controller.sv
module tb_crp16_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        run_req = 1'b0;
    logic        abort_req = 1'b0;
    logic [15:0] cpu_instr = '0;
    logic [15:0] cpu_addr_b = '0;
    logic [15:0] cpu_data_b = '0;
    logic        cpu_wren_b = 1'b0;

    // Instance A: small load window, watchdog 20.
    logic        a_load_ready, a_cpu_reset, a_mem_wren_b, a_load_err, a_timeout;
    logic [15:0] a_mem_addr_b, a_mem_data_b, a_load_addr;
    logic [1:0]  a_state;
    logic [31:0] a_run_cycles;

    // Instance B: 4-bit cycle counter, no watchdog, default load window.
    logic        b_load_ready, b_cpu_reset, b_mem_wren_b, b_load_err, b_timeout;
    logic [15:0] b_mem_addr_b, b_mem_data_b, b_load_addr;
    logic [1:0]  b_state;
    logic [3:0]  b_run_cycles;

    crp16_run_controller #(.LOAD_BASE(16'h0000), .LOAD_LIMIT(16'h0003), .CYC_W(32), .WATCHDOG(20)) u_dut (
        .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(a_load_ready),
        .run_req(run_req), .abort_req(abort_req), .cpu_reset(a_cpu_reset),
        .cpu_instr(cpu_instr), .cpu_addr_b(cpu_addr_b), .cpu_data_b(cpu_data_b), .cpu_wren_b(cpu_wren_b),
        .mem_addr_b(a_mem_addr_b), .mem_data_b(a_mem_data_b), .mem_wren_b(a_mem_wren_b),
        .state(a_state), .load_addr(a_load_addr), .load_err(a_load_err), .timeout(a_timeout),
        .run_cycles(a_run_cycles)
    );

    crp16_run_controller #(.CYC_W(4), .WATCHDOG(0)) u_sat (
        .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(b_load_ready),
        .run_req(run_req), .abort_req(abort_req), .cpu_reset(b_cpu_reset),
        .cpu_instr(cpu_instr), .cpu_addr_b(cpu_addr_b), .cpu_data_b(cpu_data_b), .cpu_wren_b(cpu_wren_b),
        .mem_addr_b(b_mem_addr_b), .mem_data_b(b_mem_data_b), .mem_wren_b(b_mem_wren_b),
        .state(b_state), .load_addr(b_load_addr), .load_err(b_load_err), .timeout(b_timeout),
        .run_cycles(b_run_cycles)
    );

    always #5 clock = ~clock;

    // RAM seen on instance A's port B, plus a count of writes.
    logic [15:0] ram [0:15];
    int          wr_cnt = 0;
    always @(posedge clock) begin
        if (a_mem_wren_b) begin
            ram[a_mem_addr_b[3:0]] <= a_mem_data_b;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'h8000) v = 16'h0000;
        return v;
    endfunction

    // Run from IDLE, present the stop word in the n-th RUN clock, then check HALT.
    task automatic run_until_stop(input int n, input string tag);
        logic [15:0] ad, da;
        logic        we;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk({tag, "_state_run"}, a_state, 2'b10);
        chk({tag, "_cpu_reset_first"}, a_cpu_reset, 1'b1);
        for (int i = 1; i <= n; i++) begin
            ad = 16'($urandom); da = 16'($urandom); we = 1'($urandom);
            cpu_addr_b = ad; cpu_data_b = da; cpu_wren_b = we;
            cpu_instr  = (i == n) ? 16'h8000 : rand_instr();
            #1;
            chk({tag, "_pass_addr"}, a_mem_addr_b, ad);
            chk({tag, "_pass_data"}, a_mem_data_b, da);
            chk({tag, "_pass_wren"}, a_mem_wren_b, we);
            tick();
        end
        cpu_instr  = 16'h0000;
        cpu_wren_b = 1'b1;
        #1;
        chk({tag, "_state_halt"}, a_state, 2'b11);
        chk({tag, "_run_cycles"}, a_run_cycles, 64'(n));
        chk({tag, "_cpu_reset_halt"}, a_cpu_reset, 1'b1);
        chk({tag, "_halt_wren"}, a_mem_wren_b, 1'b0);
    endtask

    initial begin
        logic [15:0] img [0:4];
        int          base_wr;
        int          n;

        // Reset values.
        repeat (3) tick();
        chk("rst_state", a_state, 2'b00);
        chk("rst_cpu_reset", a_cpu_reset, 1'b0);
        chk("rst_load_ready", a_load_ready, 1'b0);
        chk("rst_load_addr", a_load_addr, 16'h0000);
        chk("rst_load_err", a_load_err, 1'b0);
        chk("rst_timeout", a_timeout, 1'b0);
        chk("rst_run_cycles", a_run_cycles, 32'd0);
        reset = 1'b1;
        tick();

        // Three-word load with a gap; load_start beats a simultaneous run_req.
        load_start = 1'b1; run_req = 1'b1;
        tick();
        load_start = 1'b0; run_req = 1'b0;
        chk("prio_load_over_run", a_state, 2'b01);
        chk("load_ready", a_load_ready, 1'b1);
        img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                load_valid = 1'b0;
                #1;
                chk("load_gap_wren", a_mem_wren_b, 1'b0);
                tick();
            end
            load_valid = 1'b1; load_data = img[i]; load_last = (i == 2);
            #1;
            chk("load_wren", a_mem_wren_b, 1'b1);
            chk("load_addr_out", a_mem_addr_b, 16'(i));
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("load_done_state", a_state, 2'b00);
        chk("load_done_addr", a_load_addr, 16'd3);
        chk("load_done_err", a_load_err, 1'b0);
        for (int i = 0; i < 3; i++) chk("load_ram", ram[i], img[i]);

        // Overflow: window ends at 3, five words streamed back to back without last.
        base_wr = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) img[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = img[i];
            tick();
        end
        load_valid = 1'b0;
        chk("ovf_writes", 64'(wr_cnt - base_wr), 64'd4);
        for (int i = 0; i < 4; i++) chk("ovf_ram", ram[i], img[i]);
        chk("ovf_err", a_load_err, 1'b1);
        chk("ovf_state", a_state, 2'b00);
        chk("ovf_addr", a_load_addr, 16'h0003);
        abort_req = 1'b1;   // instance B is still loading; bring it back to IDLE
        tick();
        abort_req = 1'b0;
        chk("idle_abort_noop", a_state, 2'b00);

        // Run for 10 clocks then stop; run_req in HALT is ignored.
        run_until_stop(10, "run10");
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("halt_ignores_run", a_state, 2'b11);
        chk("halt_frozen_cycles", a_run_cycles, 32'd10);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        chk("halt_abort_state", a_state, 2'b00);
        chk("halt_abort_cpu_reset", a_cpu_reset, 1'b0);

        // Randomised run length.
        n = $urandom_range(2, 19);
        run_until_stop(n, "runrnd");
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;

        // Abort coincident with the stop word returns to IDLE.
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (3) begin
            cpu_instr = rand_instr();
            tick();
        end
        cpu_instr = 16'h8000; abort_req = 1'b1;
        tick();
        cpu_instr = 16'h0000; abort_req = 1'b0;
        chk("abort_beats_stop", a_state, 2'b00);
        chk("abort_cpu_reset", a_cpu_reset, 1'b0);

        // Watchdog at 20 on A; B saturates its 4-bit counter and keeps running.
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cpu_instr = rand_instr();
            tick();
            if (i == 19) begin
                chk("wd_before_state", a_state, 2'b10);
                chk("wd_before_timeout", a_timeout, 1'b0);
            end
        end
        cpu_instr = 16'h0000;
        chk("wd_state", a_state, 2'b11);
        chk("wd_timeout", a_timeout, 1'b1);
        chk("wd_run_cycles", a_run_cycles, 32'd20);
        chk("sat_run_cycles", b_run_cycles, 4'hF);
        chk("sat_state", b_state, 2'b10);
        chk("nowd_timeout", b_timeout, 1'b0);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        chk("timeout_sticky", a_timeout, 1'b1);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("timeout_cleared", a_timeout, 1'b0);
        chk("run_cycles_cleared", a_run_cycles, 32'd0);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;

        // load_start in HALT goes via IDLE into LOAD; abort with a word still writes it.
        run_until_stop(3, "run3");
        chk("err_sticky", a_load_err, 1'b1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("halt_load_idle", a_state, 2'b00);
        tick();
        chk("halt_load_load", a_state, 2'b01);
        chk("halt_load_err_clr", a_load_err, 1'b0);
        chk("halt_load_addr", a_load_addr, 16'h0000);
        img[0] = 16'($urandom);
        load_valid = 1'b1; load_data = img[0]; abort_req = 1'b1;
        #1;
        chk("abort_load_wren", a_mem_wren_b, 1'b1);
        tick();
        load_valid = 1'b0; abort_req = 1'b0;
        chk("abort_load_state", a_state, 2'b00);
        chk("abort_load_ram", ram[0], img[0]);
        chk("abort_load_addr", a_load_addr, 16'd1);

        // Asynchronous reset in the middle of RUN.
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (4) tick();
        cpu_wren_b = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", a_state, 2'b00);
        chk("mid_rst_cpu_reset", a_cpu_reset, 1'b0);
        chk("mid_rst_run_cycles", a_run_cycles, 32'd0);
        chk("mid_rst_wren", a_mem_wren_b, 1'b0);
        chk("mid_rst_load_addr", a_load_addr, 16'h0000);
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
